// File: rtl/mlp_weight_loader_pkg.sv
// Shared types and constants for the MLP parameter loader: FSM states,
// default reset parameters and the bias word-count helper.
package mlp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } state_e;

    // Defaults are truncated to INPUT_WIDTH / ACCUM_WIDTH where they are used.
    localparam logic [63:0] DEFAULT_WEIGHT = 64'h0000_0000_0001_0000;
    localparam logic [63:0] DEFAULT_BIAS   = 64'h0000_0000_0004_0000;

    function automatic int bias_words(input int aw, input int iw);
        return (aw + iw - 32'sd1) / iw;
    endfunction

endpackage

// File: rtl/mlp_weight_loader_if.sv
// Valid/ready word stream carrying packed weights and bias chunks.
interface mlp_weight_loader_if #(
    parameter int INPUT_WIDTH = 20
);
    logic                   s_valid;
    logic                   s_ready;
    logic [INPUT_WIDTH-1:0] s_data;
    logic                   s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/mlp_weight_loader_frame_counter.sv
// Nested neuron/word counter that walks the shadow slots of one frame.
module mlp_frame_counter #(
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_NEURONS = 3,
    parameter int BIAS_WORDS  = 3,
    parameter int NRN_W       = 2,
    parameter int WRD_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [NRN_W-1:0] nrn_idx,
    output logic [WRD_W-1:0] word_idx,
    output logic             is_bias,
    output logic             is_final
);
    localparam logic [NRN_W-1:0] LAST_NRN   = NRN_W'(NUM_NEURONS - 1);
    localparam logic [WRD_W-1:0] LAST_WRD   = WRD_W'(NUM_INPUTS + BIAS_WORDS - 1);
    localparam logic [WRD_W-1:0] FIRST_BIAS = WRD_W'(NUM_INPUTS);

    logic [NRN_W-1:0] nrn_q, nrn_d;
    logic [WRD_W-1:0] wrd_q, wrd_d;

    // Next-count: clear wins over advance; words wrap into the next neuron.
    always_comb begin
        nrn_d = nrn_q;
        wrd_d = wrd_q;
        if (clear) begin
            nrn_d = '0;
            wrd_d = '0;
        end else if (advance) begin
            if (wrd_q == LAST_WRD) begin
                wrd_d = '0;
                nrn_d = (nrn_q == LAST_NRN) ? '0 : nrn_q + NRN_W'(1);
            end else begin
                wrd_d = wrd_q + WRD_W'(1);
            end
        end else begin
            wrd_d = wrd_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nrn_q <= '0;
            wrd_q <= '0;
        end else begin
            nrn_q <= nrn_d;
            wrd_q <= wrd_d;
        end
    end

    assign nrn_idx  = nrn_q;
    assign word_idx = wrd_q;
    assign is_bias  = (wrd_q >= FIRST_BIAS);
    assign is_final = (nrn_q == LAST_NRN) && (wrd_q == LAST_WRD);

endmodule

// File: rtl/mlp_weight_loader.sv
// Streams weights/biases into shadow registers and commits a complete frame
// atomically. Optional MLP_LOADER_DEFAULTS_EN gives usable reset parameters.
module mlp_weight_loader
    import mlp_pkg::*;
#(
    parameter int INPUT_WIDTH = 20,
    parameter int ACCUM_WIDTH = 48,
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_NEURONS = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    mlp_weight_loader_if.slave                        s,
    output logic [NUM_NEURONS*NUM_INPUTS*INPUT_WIDTH-1:0] weights_flat,
    output logic [NUM_NEURONS*ACCUM_WIDTH-1:0]        biases_flat,
    output logic                                      params_valid,
    output logic                                      load_busy,
    output logic                                      load_done,
    output logic                                      frame_err
);
    localparam int BIAS_WORDS = bias_words(ACCUM_WIDTH, INPUT_WIDTH);
    localparam int WPN        = NUM_INPUTS + BIAS_WORDS;
    localparam int NRN_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int WRD_W      = $clog2(WPN);
    localparam int NW         = NUM_NEURONS * NUM_INPUTS;
    localparam int BB         = BIAS_WORDS * INPUT_WIDTH;

`ifdef MLP_LOADER_DEFAULTS_EN
    localparam logic [INPUT_WIDTH-1:0] W_RST  = INPUT_WIDTH'(DEFAULT_WEIGHT);
    localparam logic [ACCUM_WIDTH-1:0] B_RST  = ACCUM_WIDTH'(DEFAULT_BIAS);
    localparam logic                   PV_RST = 1'b1;
`else
    localparam logic [INPUT_WIDTH-1:0] W_RST  = '0;
    localparam logic [ACCUM_WIDTH-1:0] B_RST  = '0;
    localparam logic                   PV_RST = 1'b0;
`endif

    state_e                            state_q;
    logic                              s_ready_q, load_busy_q, load_done_q, frame_err_q, params_valid_q;
    logic [NW*INPUT_WIDTH-1:0]         weights_q;
    logic [NUM_NEURONS*ACCUM_WIDTH-1:0] biases_q;
    logic [INPUT_WIDTH-1:0]            shadow_w_q [NW];
    logic [ACCUM_WIDTH-1:0]            shadow_b_q [NUM_NEURONS];

    logic             accept_s, load_s, is_bias_s, is_final_s;
    logic [NRN_W-1:0] nrn_idx_s;
    logic [WRD_W-1:0] word_idx_s;
    int               chunk_sh_s;
    logic [BB-1:0]    chunk_ext_s, chunk_mask_s;

    assign accept_s  = s.s_valid && s_ready_q;
    assign load_s    = accept_s && ((state_q == IDLE) || (state_q == LOAD));
    assign s.s_ready = s_ready_q;

    mlp_frame_counter #(
        .NUM_INPUTS (NUM_INPUTS),
        .NUM_NEURONS(NUM_NEURONS),
        .BIAS_WORDS (BIAS_WORDS),
        .NRN_W      (NRN_W),
        .WRD_W      (WRD_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (load_s && (s.s_last || is_final_s)),
        .advance (load_s),
        .nrn_idx (nrn_idx_s),
        .word_idx(word_idx_s),
        .is_bias (is_bias_s),
        .is_final(is_final_s)
    );

    // Position the incoming bias chunk within the bias word, LS chunk first.
    always_comb begin
        if (is_bias_s) begin
            chunk_sh_s = (int'(word_idx_s) - NUM_INPUTS) * INPUT_WIDTH;
        end else begin
            chunk_sh_s = 32'sd0;
        end
        chunk_ext_s  = BB'(s.s_data) << chunk_sh_s;
        chunk_mask_s = BB'({INPUT_WIDTH{1'b1}}) << chunk_sh_s;
    end

    // Shadow slot writes; the bits of the top chunk above ACCUM_WIDTH fall off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < NW; j++) shadow_w_q[j] <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) shadow_b_q[n] <= '0;
        end else if (load_s) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    if (!is_bias_s && nrn_idx_s == NRN_W'(n) && word_idx_s == WRD_W'(i))
                        shadow_w_q[n*NUM_INPUTS+i] <= s.s_data;
                end
                if (is_bias_s && nrn_idx_s == NRN_W'(n))
                    shadow_b_q[n] <= (shadow_b_q[n] & ~ACCUM_WIDTH'(chunk_mask_s))
                                   | ACCUM_WIDTH'(chunk_ext_s);
            end
        end
    end

    // Frame FSM with registered handshake, status and parameter outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            s_ready_q      <= 1'b1;
            load_busy_q    <= 1'b0;
            load_done_q    <= 1'b0;
            frame_err_q    <= 1'b0;
            params_valid_q <= PV_RST;
            weights_q      <= {NW{W_RST}};
            biases_q       <= {NUM_NEURONS{B_RST}};
        end else begin
            load_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE, LOAD: begin
                    if (accept_s) begin
                        if (is_final_s && s.s_last) begin
                            state_q     <= COMMIT;
                            s_ready_q   <= 1'b0;
                            load_busy_q <= 1'b1;
                        end else if (is_final_s) begin
                            state_q     <= DRAIN;
                            load_busy_q <= 1'b1;
                        end else if (s.s_last) begin
                            state_q     <= IDLE;
                            frame_err_q <= 1'b1;
                            load_busy_q <= 1'b0;
                        end else begin
                            state_q     <= LOAD;
                            load_busy_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (accept_s && s.s_last) begin
                        state_q     <= IDLE;
                        frame_err_q <= 1'b1;
                        load_busy_q <= 1'b0;
                    end
                end
                COMMIT: begin
                    for (int j = 0; j < NW; j++)
                        weights_q[j*INPUT_WIDTH +: INPUT_WIDTH] <= shadow_w_q[j];
                    for (int n = 0; n < NUM_NEURONS; n++)
                        biases_q[n*ACCUM_WIDTH +: ACCUM_WIDTH] <= shadow_b_q[n];
                    params_valid_q <= 1'b1;
                    load_done_q    <= 1'b1;
                    state_q        <= IDLE;
                    s_ready_q      <= 1'b1;
                    load_busy_q    <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    s_ready_q   <= 1'b1;
                    load_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign weights_flat = weights_q;
    assign biases_flat  = biases_q;
    assign params_valid = params_valid_q;
    assign load_busy    = load_busy_q;
    assign load_done    = load_done_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_mlp_weight_loader.sv
// Randomised frame-level bench for mlp_weight_loader with a frame model.
module tb_mlp_weight_loader;
    localparam int IW = 20, AW = 48, NI = 4, NN = 3, BW = 3, WPN = 7, FW = 21;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mlp_weight_loader_if #(.INPUT_WIDTH(IW)) s_if ();
    logic [NN*NI*IW-1:0] weights_flat;
    logic [NN*AW-1:0]    biases_flat;
    logic                params_valid, load_busy, load_done, frame_err;

    mlp_weight_loader #(.INPUT_WIDTH(IW), .ACCUM_WIDTH(AW), .NUM_INPUTS(NI), .NUM_NEURONS(NN)) dut (
        .clk(clk), .rst(rst), .s(s_if.slave),
        .weights_flat(weights_flat), .biases_flat(biases_flat), .params_valid(params_valid),
        .load_busy(load_busy), .load_done(load_done), .frame_err(frame_err)
    );

    int n_pass = 0, n_total = 0;
    int ld_cnt = 0, fe_cnt = 0, hs_cnt = 0;
    logic [NN*NI*IW-1:0] exp_w, rst_w;
    logic [NN*AW-1:0]    exp_b, rst_b;
    logic                exp_pv, rst_pv;
    logic [IW-1:0]       fw [0:31];

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) begin
        if (load_done === 1'b1) ld_cnt <= ld_cnt + 1;
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (s_if.s_valid === 1'b1 && s_if.s_ready === 1'b1) hs_cnt <= hs_cnt + 1;
    end

    // Reference: a well-framed set is words grouped 7 per neuron, bias chunks LS first.
    task automatic model_commit();
        logic [BW*IW-1:0] b;
        for (int n = 0; n < NN; n++) begin
            for (int i = 0; i < NI; i++) exp_w[(n*NI+i)*IW +: IW] = fw[n*WPN+i];
            for (int c = 0; c < BW; c++) b[c*IW +: IW] = fw[n*WPN+NI+c];
            exp_b[n*AW +: AW] = b[AW-1:0];
        end
        exp_pv = 1'b1;
    endtask

    task automatic send_word(input logic [IW-1:0] d, input logic last, input int gap);
        int t;
        s_if.s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        s_if.s_last  = last;
        t = 0;
        while (s_if.s_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check_eq("hs_timeout", 256'(t), 256'(0));
        @(posedge clk);
        #1;
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_w"},  256'(weights_flat), 256'(exp_w));
        check_eq({tag, "_b"},  256'(biases_flat),  256'(exp_b));
        check_eq({tag, "_pv"}, 256'(params_valid), 256'(exp_pv));
    endtask

    task automatic run_frame(input int len, input bit seq, input bit gaps, input string tag);
        int ld0, fe0, hs0;
        bit ok;
        for (int k = 0; k < len; k++) fw[k] = seq ? IW'(k + 1) : IW'($urandom);
        ld0 = ld_cnt; fe0 = fe_cnt; hs0 = hs_cnt;
        for (int k = 0; k < len; k++)
            send_word(fw[k], (k == len - 1), gaps ? int'($urandom_range(0, 3)) : 0);
        ok = (len == FW);
        if (ok) model_commit();
        @(negedge clk);
        check_eq({tag, "_ready1"}, 256'(s_if.s_ready), 256'(!ok));
        check_eq({tag, "_busy1"},  256'(load_busy),    256'(ok));
        check_eq({tag, "_done1"},  256'(load_done),    256'(0));
        check_eq({tag, "_err1"},   256'(frame_err),    256'(!ok));
        @(negedge clk);
        check_eq({tag, "_done2"},  256'(load_done),    256'(ok));
        check_eq({tag, "_err2"},   256'(frame_err),    256'(0));
        check_eq({tag, "_ready2"}, 256'(s_if.s_ready), 256'(1));
        check_eq({tag, "_busy2"},  256'(load_busy),    256'(0));
        check_outputs(tag);
        @(negedge clk);
        check_eq({tag, "_done3"},  256'(load_done),    256'(0));
        check_eq({tag, "_ndone"},  256'(ld_cnt - ld0), 256'(ok));
        check_eq({tag, "_nerr"},   256'(fe_cnt - fe0), 256'(!ok));
        check_eq({tag, "_nacc"},   256'(hs_cnt - hs0), 256'(len));
    endtask

    initial begin
        logic [3*IW-1:0] b0;
`ifdef MLP_LOADER_DEFAULTS_EN
        rst_w = {(NN*NI){20'h10000}}; rst_b = {NN{48'h40000}}; rst_pv = 1'b1;
`else
        rst_w = '0; rst_b = '0; rst_pv = 1'b0;
`endif
        exp_w = rst_w; exp_b = rst_b; exp_pv = rst_pv;
        rst = 1'b0;
        s_if.s_valid = 1'b0; s_if.s_data = '0; s_if.s_last = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs("reset");
        check_eq("reset_ready", 256'(s_if.s_ready), 256'(1));
        check_eq("reset_busy",  256'(load_busy), 256'(0));
        check_eq("reset_done",  256'(load_done), 256'(0));
        check_eq("reset_err",   256'(frame_err), 256'(0));
        rst = 1'b1;

        // Values 1..21 back to back.
        run_frame(FW, 1'b1, 1'b0, "seq");
        check_eq("seq_n0_w", 256'(weights_flat[4*IW-1:0]), 256'({20'd4, 20'd3, 20'd2, 20'd1}));
        b0 = {20'd7, 20'd6, 20'd5};
        check_eq("seq_n0_b", 256'(biases_flat[AW-1:0]), 256'(b0[AW-1:0]));

        run_frame(10, 1'b0, 1'b0, "short");
        run_frame(FW, 1'b0, 1'b0, "after_short");
        run_frame(FW + 3, 1'b0, 1'b0, "drain");
        run_frame(FW, 1'b1, 1'b1, "gaps");

        // Reset in the middle of a frame.
        for (int k = 0; k < 11; k++) send_word(IW'($urandom), 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_w = rst_w; exp_b = rst_b; exp_pv = rst_pv;
        @(negedge clk);
        check_outputs("midrst");
        check_eq("midrst_ready", 256'(s_if.s_ready), 256'(1));
        check_eq("midrst_busy",  256'(load_busy), 256'(0));
        rst = 1'b1;
        run_frame(FW, 1'b0, 1'b0, "post_rst");

        for (int r = 0; r < 8; r++) begin
            int kind, len;
            kind = int'($urandom_range(0, 3));
            len  = (kind < 2) ? FW : (kind == 2) ? int'($urandom_range(1, FW - 1))
                                                 : int'($urandom_range(FW + 1, FW + 5));
            run_frame(len, 1'b0, 1'($urandom_range(0, 1)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d checks done", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/mlp_weight_loader.md
# mlp_weight_loader

Streaming parameter writer for the CORDIC MLP layer. It accepts weights and biases as a valid/ready word stream and assembles them in shadow registers. Once a complete, well-framed set is received, it commits them atomically to the flattened `weights_flat` and `biases_flat` buses that feed the layer's neurons. The layer therefore never computes with a partially updated parameter set, and hard-coded weight initialisation is no longer needed.

## Interface
- `INPUT_WIDTH`, 20: weight and stream word width.
- `ACCUM_WIDTH`, 48: bias width.
- `NUM_INPUTS`, 4: weights per neuron.
- `NUM_NEURONS`, 3: neurons in the layer, 1 to 8.
- `clk`, in, 1: single clock. One clock, reset is asynchronous and active-low.
- `rst`, in, 1: asynchronous active-low reset.
- `s_valid`, in, 1: stream word valid.
- `s_ready`, out, 1: loader can accept a word.
- `s_data`, in, `INPUT_WIDTH`: stream word.
- `s_last`, in, 1: final word of a frame.
- `weights_flat`, out, `NUM_NEURONS*NUM_INPUTS*INPUT_WIDTH`: neuron n, input i sits at slice `[(n*NUM_INPUTS+i)*INPUT_WIDTH +: INPUT_WIDTH]`.
- `biases_flat`, out, `NUM_NEURONS*ACCUM_WIDTH`: neuron n at `[n*ACCUM_WIDTH +: ACCUM_WIDTH]`.
- `params_valid`, out, 1: a committed parameter set is present.
- `load_busy`, out, 1: a frame is in progress (state LOAD, DRAIN or COMMIT).
- `load_done`, out, 1: one-cycle pulse on commit.
- `frame_err`, out, 1: one-cycle pulse when a frame is rejected.

## Operation
- `BIAS_WORDS = ceil(ACCUM_WIDTH/INPUT_WIDTH)`, which is 3 at the defaults.
- `FRAME_WORDS = NUM_NEURONS*(NUM_INPUTS+BIAS_WORDS)`, which is 21 at the defaults.
- Frame order, for each neuron 0..N-1: weights w0..w(NUM_INPUTS-1), then the bias chunks least-significant first.
- Bias assembly: chunks are concatenated and truncated to `ACCUM_WIDTH`. The top chunk's excess bits are ignored.
- A word transfers on `s_valid && s_ready`. Counters `nrn_idx` and `word_idx` select the shadow slot to write.
- States:
  - IDLE: `s_ready`=1. The first accepted word is written to shadow slot 0 and the state moves to LOAD, or straight to COMMIT/error when `FRAME_WORDS`=1.
  - LOAD: `s_ready`=1. Each accepted word writes the next slot.
  - COMMIT: `s_ready`=0 for exactly one cycle. Shadow copies to the outputs, `params_valid`←1, `load_done` pulses, then the state returns to IDLE.
  - DRAIN: `s_ready`=1. Words are discarded until one with `s_last`. That word raises `frame_err` and the state returns to IDLE.
- Framing rules:
  - Word `FRAME_WORDS-1` accepted with `s_last`=1: go to COMMIT.
  - Word `FRAME_WORDS-1` accepted with `s_last`=0: go to DRAIN.
  - `s_last`=1 on any earlier word: `frame_err` pulses and the state returns to IDLE.
- Rejected frames leave the outputs and `params_valid` unchanged, and the shadow contents are abandoned.
- `s_valid` is ignored while `s_ready`=0. The upstream source holds the word until the handshake completes.
- Reset mid-frame: state←IDLE, counters←0, outputs←reset values, `load_done`/`frame_err`←0.

## Timing
- Reset values:
  - `s_ready`=1, `load_busy`=0, `load_done`=0, `frame_err`=0.
  - `weights_flat`, `biases_flat` and `params_valid` follow the Configuration section.
- Throughput: one word per cycle.
- Commit latency: if the final word is accepted at edge E, COMMIT is the cycle after E. The outputs, `params_valid` and `load_done` all become visible after edge E+1, and `load_done` is high for that one cycle only. The next frame's first word can be accepted at edge E+2.
- `frame_err` is registered and asserts in the cycle after the offending handshake.
- All outputs are registered; there are no combinational paths from `s_*` to the outputs except `s_ready`, which depends only on state.

## Configuration
- `MLP_LOADER_DEFAULTS_EN` defined:
  - Reset loads every weight with `INPUT_WIDTH'h10000` and every bias with `ACCUM_WIDTH'h40000`.
  - `params_valid`=1 at reset, so the layer is usable before any load.
- Undefined:
  - Weights and biases reset to 0 and `params_valid`=0.
  - `params_valid` is set only by the first successful commit.

## Structure
- Package `mlp_pkg` holds:
  - the state enum {IDLE, LOAD, DRAIN, COMMIT};
  - the default weight/bias constants;
  - the `bias_words(aw,iw)` constant function.
- One sub-module, `mlp_frame_counter`: a nested neuron/word counter. Outputs: `nrn_idx`, `word_idx`, `is_bias`, `is_final`. Inputs: clear, advance.

## Test plan
All scenarios use the default parameters (frame of 21 words).
1. Reset with the macro undefined → `params_valid`=0, buses all 0, `s_ready`=1.
2. 21 back-to-back words with values 1..21 and `s_last` on word 21 → `weights_flat` neuron0 = {4,3,2,1}, `biases_flat` neuron0 = {7,6,5} concatenated, `load_done` pulses once 2 cycles after the final handshake, `s_ready`=0 for exactly 1 cycle.
3. `s_last` asserted on word 10 → `frame_err` pulses, the previously committed buses are unchanged, and the next full frame commits correctly.
4. Word 21 sent without `s_last`, followed by 3 extra words (the last with `s_last`) → all extras accepted, one `frame_err` pulse, no commit.
5. Random `s_valid` gaps during a 21-word frame → same result as scenario 2.
6. Reset asserted at word 12, then a full frame → nothing is committed from the partial frame, the post-reset frame commits, and `params_valid` goes 0→1.
